// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_responder
// Description : Clock-oversampled SPI-flash slave answering READ (0x03) and
//               JEDEC-ID (0x9F) from an internal, side-loadable byte memory.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk_i,
    input  logic                 cs_i,
    input  logic                 mosi_i,
    output logic                 miso_o,
    output logic                 busy_o,
    input  logic                 load_en_i,
    input  logic [ADDR_BITS-1:0] load_addr_i,
    input  logic [7:0]           load_data_i
);

    localparam int unsigned c_MEM_DEPTH = 1 << ADDR_BITS;
    localparam logic [7:0]  c_OP_READ   = 8'h03;
    localparam logic [7:0]  c_OP_JEDEC  = 8'h9F;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_ID     = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    logic                 sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic                 cs_meta_q, cs_sync_q;
    logic                 mosi_meta_q, mosi_sync_q;

    state_t               state_q;
    logic [4:0]           bit_cnt_q;
    logic [6:0]           opcode_q;
    logic [ADDR_BITS-2:0] addr_q;
    logic [ADDR_BITS-1:0] ptr_q;
    logic [6:0]           dout_q;
    logic [23:0]          id_q;
    logic                 miso_q;
    logic                 busy_q;

    logic [7:0]           mem_q [c_MEM_DEPTH];

    logic                 w_rise;
    logic                 w_fall;
    logic [7:0]           w_opcode_next;
    logic [ADDR_BITS-1:0] w_addr_next;
    logic [7:0]           w_mem_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= sclk_i;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= cs_i;
            cs_sync_q   <= cs_meta_q;
            mosi_meta_q <= mosi_i;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign w_rise        = sclk_sync_q & ~sclk_prev_q;
    assign w_fall        = ~sclk_sync_q & sclk_prev_q;
    // Only the low ADDR_BITS of the 24-bit address are kept; upper bits shift out.
    assign w_opcode_next = {opcode_q, mosi_sync_q};
    assign w_addr_next   = {addr_q, mosi_sync_q};
    assign w_mem_rd      = mem_q[ptr_q];

    // Load port is independent of reset so contents survive and can be preloaded.
    always_ff @(posedge clk) begin
        if (load_en_i) begin
            mem_q[load_addr_i] <= load_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            opcode_q  <= '0;
            addr_q    <= '0;
            ptr_q     <= '0;
            dout_q    <= '0;
            id_q      <= '0;
            miso_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else if (cs_sync_q) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q   <= ST_CMD;
                    bit_cnt_q <= '0;
                    miso_q    <= 1'b0;
                    busy_q    <= 1'b0;
                end
                ST_CMD: begin
                    if (w_rise) begin
                        opcode_q <= w_opcode_next[6:0];
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q <= '0;
                            if (w_opcode_next == c_OP_READ) begin
                                state_q <= ST_ADDR;
                                busy_q  <= 1'b1;
                            end else if (w_opcode_next == c_OP_JEDEC) begin
                                state_q <= ST_ID;
                                busy_q  <= 1'b1;
                                id_q    <= JEDEC_ID;
                            end else begin
                                state_q <= ST_IGNORE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_rise) begin
                        addr_q <= w_addr_next[ADDR_BITS-2:0];
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_q <= '0;
                            ptr_q     <= w_addr_next;
                            state_q   <= ST_DATA;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    // Byte-boundary fall latches the next byte and drives its MSB at once.
                    if (w_fall) begin
                        if (bit_cnt_q[2:0] == 3'd0) begin
                            miso_q <= w_mem_rd[7];
                            dout_q <= w_mem_rd[6:0];
                            ptr_q  <= ptr_q + ADDR_BITS'(1);
                        end else begin
                            miso_q <= dout_q[6];
                            dout_q <= {dout_q[5:0], 1'b0};
                        end
                        bit_cnt_q <= {2'b00, bit_cnt_q[2:0] + 3'd1};
                    end
                end
                ST_ID: begin
                    // Zeros shift in behind the ID, so miso idles low after 24 bits.
                    if (w_fall) begin
                        miso_q <= id_q[23];
                        id_q   <= {id_q[22:0], 1'b0};
                    end
                end
                ST_IGNORE: begin
                    miso_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    miso_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign miso_o = miso_q;
    assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI-flash responder that models the slave end of the flash link driven by the core's memory-read controller. Runs entirely on the system clock: oversamples `sclk`, `cs` and `mosi`, decodes READ (0x03) and JEDEC-ID (0x9F) commands, and streams bytes from an internal byte memory on `miso`. Used as the on-chip flash stand-in for simulation, FPGA bring-up and self-test. A side load port lets the bench or host preload its contents.

## Interface
- `ADDR_BITS`, 8: internal memory is 2^ADDR_BITS bytes. Incoming 24-bit address is taken modulo 2^ADDR_BITS.
- `JEDEC_ID`, 24'hEF4016: 3-byte ID returned by 0x9F, MSB byte first.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `sclk` input 1: SPI clock from the initiator, mode 0, asynchronous to `clk`.
- `cs` input 1: chip select, active-low, asynchronous.
- `mosi` input 1: serial data in, MSB first.
- `miso` output 1: serial data out, MSB first, registered.
- `busy` output 1: high while a recognised command (0x03/0x9F) is in progress.
- `load_en` input 1: when high, writes `load_data` to `mem[load_addr]` this cycle.
- `load_addr` input ADDR_BITS: memory write address.
- `load_data` input 8: memory write byte.

## Operation
- `sclk`, `cs` and `mosi` each pass through a 2-flop synchroniser.
- Edges are detected on the synchronised `sclk` using a third delay flop:
  - rise = sync & ~prev
  - fall = ~sync & prev
- The synchronised `cs` high forces state IDLE in the same cycle it is seen, overriding any edge.
- States:
  - IDLE: `miso`=0, `busy`=0. Synchronised `cs` low → CMD, with bit counter=0.
  - CMD: shift `mosi` into the opcode on each rise. After the 8th rise:
    - 0x03 → ADDR, `busy`=1.
    - 0x9F → ID, `busy`=1, and the ID shift register is loaded with JEDEC_ID.
    - anything else → IGNORE.
  - ADDR: shift 24 bits on rises. After the 24th rise, load the address pointer with addr[ADDR_BITS-1:0], then go to DATA.
  - DATA:
    - On each fall at a byte boundary, latch `mem[ptr]` into the 8-bit output shift register, drive its MSB onto `miso`, and increment `ptr`.
    - On other falls, shift left and drive the next bit.
    - `ptr` wraps from 2^ADDR_BITS-1 to 0.
    - Streaming continues until `cs` rises.
  - ID:
    - On each fall, drive the next bit of the 24-bit ID.
    - After 24 bits, drive 0 until `cs` rises.
  - IGNORE: `miso`=0, no memory access, wait for `cs` high.
- The first DATA/ID bit is driven on the fall that follows the last command/address rise, so it is valid before the next rise.
- `mosi` is ignored in DATA, ID and IGNORE.
- Load port:
  - A write takes effect at the clock edge; it is accepted in any state, including during reset.
  - If a load to `mem[ptr]` and the byte latch of that same address occur in the same cycle, the latch returns the old byte.
- Reset values: state IDLE, `miso` 0, `busy` 0, bit counter 0, `ptr` 0, shift registers 0. Memory contents are not cleared.
- Reset mid-transfer aborts the transfer. After reset releases, the block waits in IDLE. If `cs` is still low at that point, the partial transfer is parsed as a new command from the current bit, so the initiator must raise `cs` before restarting.

## Timing
- Input-to-action latency:
  - 3 `clk` cycles from a pin edge to the internal rise/fall event.
  - `miso` changes on the cycle after the fall event, i.e. 4 `clk` after the `sclk` pin falls.
- Requirements on the initiator:
  - `sclk` high and low phases each ≥ 6 `clk`.
  - `cs` setup to the first `sclk` rise ≥ 4 `clk`.
  - `cs` high time between transactions ≥ 4 `clk`.
- Initiator samples `miso` on the `sclk` rise; the ≥6-clk low phase guarantees ≥2 clk of setup.
- `busy` rises 1 `clk` after the 8th rise event of a valid opcode, and falls 1 `clk` after synchronised `cs` goes high.
- Memory read is combinational from `ptr`; no wait states.

## Test plan
- Reset: hold `rst` 1 for 3 clk with `cs`=1, then release → `miso`=0, `busy`=0. Preload `mem[0..7]` = 00,11,…,77 via the load port.
- READ 0x03, addr 0x000004, 32 `sclk` after the address → received word bytes 44,55,66,77. `busy`=1 during the transfer and 0 within 4 clk of `cs` high.
- Wrap: `ADDR_BITS`=8, `mem[FE]`=A5, `mem[FF]`=5A, `mem[00]`=00; READ addr 0x1234FE, 3 bytes → A5,5A,00 (upper address bits ignored).
- JEDEC: send 0x9F then 32 clocks → EF,40,16,00. Then send 0x05 → `miso` stays 0 and `busy` stays 0 for the whole transaction.
- Abort/restart: raise `cs` after 5 address bits, then start READ addr 0x000001 → first byte 11. Asserting `rst` mid-DATA forces `miso`=0 and `busy`=0 on the next clk.
- Load collision: issue `load_en` to `ptr`'s address with 0xCC on the exact byte-latch cycle → old byte is returned. A re-read of that address returns CC.
